exp_align_pipe: RTL and testbench
=================================

EXP_ALIGN_PIPE -- requirements
Module: exp_align_pipe

Interface
REQ-001 SHALL have parameter EXP_WIDTH, default 11, exponent field width (biased, unsigned).
REQ-002 SHALL have parameter MAN_WIDTH, default 53, significand width including hidden bit.
REQ-003 SHALL have ports: in_clk  input  1  sole clock; in_rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have ports: in_valid  input  1  operand pair valid; out_inReady  output  1  block accepts operand pair.
REQ-005 SHALL have ports: in_signA, in_signB  input  1  operand signs; in_expA, in_expB  input  EXP_WIDTH  biased exponents; in_manA, in_manB  input  MAN_WIDTH  significands.
REQ-006 SHALL have port in_flush  input  1  synchronous pipeline clear.
REQ-007 SHALL have ports: out_valid  output  1  result valid; in_outReady  input  1  downstream accepts result.
REQ-008 SHALL have ports: out_swap  output  1  (0 = A larger magnitude, 1 = B); out_signBig, out_signSmall  output  1; out_bigExp  output  EXP_WIDTH; out_diff  output  EXP_WIDTH  unsigned exponent difference.
REQ-009 SHALL have ports: out_bigMan  output  MAN_WIDTH+3  larger significand with three zero LSBs; out_smallMan  output  MAN_WIDTH+3  aligned smaller significand with guard, round and sticky LSBs.

Function
REQ-010 Magnitude compare SHALL be unsigned: expA vs expB; on equal exponents, manA vs manB; full tie SHALL select A (out_swap=0).
REQ-011 out_diff SHALL be |expA-expB|, computed at EXP_WIDTH+1 bits with no wrap-around; out_bigExp SHALL be the larger exponent.
REQ-012 Stage 1 SHALL register the compare result, swapped operands and diff; stage 2 SHALL register the shifted smaller significand.
REQ-013 Shift: {man,3'b000} logical right by diff; sticky (LSB) SHALL be the OR of all bits shifted past it, including its own.
REQ-014 If diff >= MAN_WIDTH+3, out_smallMan SHALL be 0 except sticky = OR of the smaller significand; if diff = 0, it SHALL be unshifted.
REQ-015 Latency SHALL be exactly 2 cycles from accepted input (in_valid & out_inReady) to out_valid with no stall; throughput 1 pair/cycle.
REQ-016 Each stage SHALL hold a valid bit; a stage SHALL load when empty or when its contents move on in the same cycle.
REQ-017 out_inReady SHALL be !s1_valid | !s2_valid | in_outReady, combinational from stage state and in_outReady only, never from in_valid.
REQ-018 With out_valid=1 and in_outReady=0, all out_* data SHALL remain stable until the transfer.
REQ-019 Simultaneous accept and drain in one cycle SHALL preserve every transaction, with no loss or duplication.
REQ-020 in_flush SHALL clear both valid bits on the next edge and drop any input accepted that cycle; flush SHALL override all other updates.
REQ-021 Data registers SHALL NOT be required to clear on flush; only valid bits are architecturally visible.

Reset
REQ-022 in_rst assertion SHALL asynchronously clear s1_valid, s2_valid and all data registers to 0: out_valid=0, out_swap=0, data outputs 0, out_inReady=1.
REQ-023 Reset mid-transfer SHALL discard all in-flight pairs; the first accepted input after deassertion SHALL emerge 2 cycles later.

Structure
REQ-024 A shared package fp_pkg SHALL hold default EXP_WIDTH/MAN_WIDTH constants and GRS_BITS=3, reused by the mantissa adder and normaliser.
REQ-025 The sticky-preserving right shifter SHALL be a separate combinational sub-module, sticky_shr, parametrised on width and shift-amount width.

Verification
REQ-026 expA=0x400, expB=0x3FE, manA=manB=0x10000000000000 -> after 2 cycles: swap=0, diff=2, bigExp=0x400, smallMan=0x10000000000000<<1 with G,R,S=0.
REQ-027 expA=expB=0x3FF, manB>manA -> swap=1, diff=0, bigMan=manB<<3, smallMan=manA<<3 unshifted.
REQ-028 expA=0x000, expB=0x7FE, manA=1 -> swap=1, diff=0x7FE (no wrap), smallMan=0x...001 (sticky only).
REQ-029 Stream 8 pairs back-to-back, hold in_outReady=0 for 3 cycles mid-stream -> out_inReady drops after both stages fill, all 8 results in order, data stable while stalled.
REQ-030 Assert in_flush with both stages full and in_valid=1 -> out_valid=0 next cycle, no flushed pair ever emerges; assert in_rst mid-stream -> outputs 0 immediately, out_inReady=1.

Source files
------------

// File: rtl/fp_pkg.sv
// Shared floating-point datapath constants: default field widths and the
// guard/round/sticky extension used by the align, add and normalise stages.
package fp_pkg;

    localparam int unsigned EXP_WIDTH_DFLT = 11;
    localparam int unsigned MAN_WIDTH_DFLT = 53;
    localparam int unsigned GRS_BITS       = 3;

    // Which input operand ended up on the "big" side of the alignment.
    typedef enum logic {
        SelA = 1'b0,
        SelB = 1'b1
    } op_sel_e;

endpackage

// File: rtl/sticky_shr.sv
// Logical right shifter whose LSB collects the OR of every bit shifted past it,
// so no discarded precision is lost to rounding.
module sticky_shr #(
    parameter int unsigned WIDTH       = 56,
    parameter int unsigned SHIFT_WIDTH = 11
) (
    input  logic [WIDTH-1:0]       in_data,
    input  logic [SHIFT_WIDTH-1:0] in_shamt,
    output logic [WIDTH-1:0]       out_data
);

    localparam logic [WIDTH-1:0] ALL_ONES = '1;

    logic [WIDTH-1:0] shifted;
    logic [WIDTH-1:0] lost_mask;
    logic             sticky;

    // Shifts of WIDTH or more give shifted=0 and an all-ones mask, so the
    // out-of-range case collapses to "sticky = OR of the input" naturally.
    always_comb begin
        shifted   = in_data >> in_shamt;
        lost_mask = ~(ALL_ONES << in_shamt);
        sticky    = shifted[0] | (|(in_data & lost_mask));
        out_data  = {shifted[WIDTH-1:1], sticky};
    end

endmodule

// File: rtl/exp_align_pipe.sv
// Two-stage exponent alignment for FP add: stage 1 orders the operands by
// magnitude and takes the exponent difference, stage 2 aligns the smaller one.
module exp_align_pipe
    import fp_pkg::*;
#(
    parameter int unsigned EXP_WIDTH = EXP_WIDTH_DFLT,
    parameter int unsigned MAN_WIDTH = MAN_WIDTH_DFLT
) (
    input  logic                           in_clk,
    input  logic                           in_rst,
    input  logic                           in_valid,
    output logic                           out_inReady,
    input  logic                           in_signA,
    input  logic                           in_signB,
    input  logic [EXP_WIDTH-1:0]           in_expA,
    input  logic [EXP_WIDTH-1:0]           in_expB,
    input  logic [MAN_WIDTH-1:0]           in_manA,
    input  logic [MAN_WIDTH-1:0]           in_manB,
    input  logic                           in_flush,
    output logic                           out_valid,
    input  logic                           in_outReady,
    output logic                           out_swap,
    output logic                           out_signBig,
    output logic                           out_signSmall,
    output logic [EXP_WIDTH-1:0]           out_bigExp,
    output logic [EXP_WIDTH-1:0]           out_diff,
    output logic [MAN_WIDTH+GRS_BITS-1:0]  out_bigMan,
    output logic [MAN_WIDTH+GRS_BITS-1:0]  out_smallMan
);

    localparam int unsigned ALIGN_WIDTH = MAN_WIDTH + GRS_BITS;

    // Stage 1 state
    logic                   s1_valid_q;
    op_sel_e                s1_swap_q;
    logic                   s1_sign_big_q;
    logic                   s1_sign_small_q;
    logic [EXP_WIDTH-1:0]   s1_big_exp_q;
    logic [EXP_WIDTH-1:0]   s1_diff_q;
    logic [MAN_WIDTH-1:0]   s1_big_man_q;
    logic [MAN_WIDTH-1:0]   s1_small_man_q;

    // Stage 2 state
    logic                   s2_valid_q;
    op_sel_e                s2_swap_q;
    logic                   s2_sign_big_q;
    logic                   s2_sign_small_q;
    logic [EXP_WIDTH-1:0]   s2_big_exp_q;
    logic [EXP_WIDTH-1:0]   s2_diff_q;
    logic [ALIGN_WIDTH-1:0] s2_big_man_q;
    logic [ALIGN_WIDTH-1:0] s2_small_man_q;

    // Handshake
    logic s1_ready;
    logic s2_ready;
    logic s1_load;
    logic s2_load;

    always_comb begin
        s2_ready    = !s2_valid_q || in_outReady;
        s1_ready    = !s1_valid_q || s2_ready;
        s1_load     = in_valid && s1_ready;
        s2_load     = s1_valid_q && s2_ready;
        out_inReady = s1_ready;
    end

    // Stage 1 compare: both one-bit-wider differences are formed and their
    // borrow bits double as the exponent comparators.
    logic [EXP_WIDTH:0]   diff_ab;
    logic [EXP_WIDTH:0]   diff_ba;
    logic                 exp_a_gt;
    logic                 exp_b_gt;
    logic                 a_big;
    op_sel_e              swap_d;
    logic [EXP_WIDTH-1:0] diff_d;

    always_comb begin
        diff_ab  = {1'b0, in_expA} - {1'b0, in_expB};
        diff_ba  = {1'b0, in_expB} - {1'b0, in_expA};
        exp_a_gt = diff_ba[EXP_WIDTH];
        exp_b_gt = diff_ab[EXP_WIDTH];
        // Full tie keeps A on the big side.
        a_big    = exp_a_gt || (!exp_b_gt && (in_manA >= in_manB));
        swap_d   = a_big ? SelA : SelB;
        diff_d   = a_big ? diff_ab[EXP_WIDTH-1:0] : diff_ba[EXP_WIDTH-1:0];
    end

    // Stage 2 alignment
    logic [ALIGN_WIDTH-1:0] small_ext;
    logic [ALIGN_WIDTH-1:0] small_aligned;

    assign small_ext = {s1_small_man_q, {GRS_BITS{1'b0}}};

    sticky_shr #(
        .WIDTH       (ALIGN_WIDTH),
        .SHIFT_WIDTH (EXP_WIDTH)
    ) u_sticky_shr (
        .in_data  (small_ext),
        .in_shamt (s1_diff_q),
        .out_data (small_aligned)
    );

    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            s1_valid_q      <= 1'b0;
            s1_swap_q       <= SelA;
            s1_sign_big_q   <= 1'b0;
            s1_sign_small_q <= 1'b0;
            s1_big_exp_q    <= '0;
            s1_diff_q       <= '0;
            s1_big_man_q    <= '0;
            s1_small_man_q  <= '0;
            s2_valid_q      <= 1'b0;
            s2_swap_q       <= SelA;
            s2_sign_big_q   <= 1'b0;
            s2_sign_small_q <= 1'b0;
            s2_big_exp_q    <= '0;
            s2_diff_q       <= '0;
            s2_big_man_q    <= '0;
            s2_small_man_q  <= '0;
        end else begin
            // Flush only needs to kill the valid bits; stale data is invisible.
            if (in_flush) begin
                s1_valid_q <= 1'b0;
                s2_valid_q <= 1'b0;
            end else begin
                if (s1_ready) s1_valid_q <= in_valid;
                if (s2_ready) s2_valid_q <= s1_valid_q;
            end

            if (s1_load) begin
                s1_swap_q       <= swap_d;
                s1_sign_big_q   <= a_big ? in_signA : in_signB;
                s1_sign_small_q <= a_big ? in_signB : in_signA;
                s1_big_exp_q    <= a_big ? in_expA : in_expB;
                s1_diff_q       <= diff_d;
                s1_big_man_q    <= a_big ? in_manA : in_manB;
                s1_small_man_q  <= a_big ? in_manB : in_manA;
            end

            if (s2_load) begin
                s2_swap_q       <= s1_swap_q;
                s2_sign_big_q   <= s1_sign_big_q;
                s2_sign_small_q <= s1_sign_small_q;
                s2_big_exp_q    <= s1_big_exp_q;
                s2_diff_q       <= s1_diff_q;
                s2_big_man_q    <= {s1_big_man_q, {GRS_BITS{1'b0}}};
                s2_small_man_q  <= small_aligned;
            end
        end
    end

    always_comb begin
        out_valid     = s2_valid_q;
        out_swap      = (s2_swap_q == SelB);
        out_signBig   = s2_sign_big_q;
        out_signSmall = s2_sign_small_q;
        out_bigExp    = s2_big_exp_q;
        out_diff      = s2_diff_q;
        out_bigMan    = s2_big_man_q;
        out_smallMan  = s2_small_man_q;
    end

endmodule

// File: tb/tb_exp_align_pipe.sv
// Directed bench for exp_align_pipe: scoreboard of expected results computed
// arithmetically from accepted inputs, plus literal checks on known vectors.
module tb_exp_align_pipe;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        out_inReady;
    logic        in_signA = 1'b0, in_signB = 1'b0;
    logic [10:0] in_expA = '0, in_expB = '0;
    logic [52:0] in_manA = '0, in_manB = '0;
    logic        in_flush = 1'b0;
    logic        out_valid;
    logic        in_outReady = 1'b1;
    logic        out_swap, out_signBig, out_signSmall;
    logic [10:0] out_bigExp, out_diff;
    logic [55:0] out_bigMan, out_smallMan;

    exp_align_pipe dut (
        .in_clk        (clk),
        .in_rst        (rst),
        .in_valid      (in_valid),
        .out_inReady   (out_inReady),
        .in_signA      (in_signA),
        .in_signB      (in_signB),
        .in_expA       (in_expA),
        .in_expB       (in_expB),
        .in_manA       (in_manA),
        .in_manB       (in_manB),
        .in_flush      (in_flush),
        .out_valid     (out_valid),
        .in_outReady   (in_outReady),
        .out_swap      (out_swap),
        .out_signBig   (out_signBig),
        .out_signSmall (out_signSmall),
        .out_bigExp    (out_bigExp),
        .out_diff      (out_diff),
        .out_bigMan    (out_bigMan),
        .out_smallMan  (out_smallMan)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int rx    = 0;
    logic saw_not_ready = 1'b0;

    typedef struct {
        int          acc;
        logic        swap;
        logic        sb;
        logic        ss;
        logic [10:0] be;
        logic [10:0] df;
        logic [55:0] bm;
        logic [55:0] sm;
    } exp_t;

    exp_t q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic exp_t model(input logic sa, input logic sb,
                                   input logic [10:0] ea, input logic [10:0] eb,
                                   input logic [52:0] ma, input logic [52:0] mb);
        exp_t        r;
        logic        a_big;
        int          d;
        logic [52:0] small_m;
        logic [63:0] full, shifted, lost;
        a_big   = (ea > eb) || (ea == eb && ma >= mb);
        r.acc   = 0;
        r.swap  = !a_big;
        r.sb    = a_big ? sa : sb;
        r.ss    = a_big ? sb : sa;
        r.be    = a_big ? ea : eb;
        d       = a_big ? (int'(ea) - int'(eb)) : (int'(eb) - int'(ea));
        r.df    = d[10:0];
        r.bm    = {(a_big ? ma : mb), 3'b000};
        small_m = a_big ? mb : ma;
        full    = {8'b0, small_m, 3'b000};
        if (d >= 56) begin
            r.sm = {55'b0, |small_m};
        end else begin
            shifted = full >> d;
            lost    = full & ((64'd1 << (d + 1)) - 64'd1);
            r.sm    = {shifted[55:1], |lost};
        end
        return r;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Per-cycle scoreboard: valid timing, ready, and data of the head entry.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            q.delete();
            chk("rst_valid", {63'b0, out_valid}, 64'd0);
            chk("rst_inready", {63'b0, out_inReady}, 64'd1);
        end else begin
            chk("valid", {63'b0, out_valid}, {63'b0, (q.size() > 0 && (cyc - q[0].acc) >= 1)});
            chk("inready", {63'b0, out_inReady}, {63'b0, (q.size() < 2 || in_outReady)});
            if (!out_inReady) saw_not_ready = 1'b1;
            if (out_valid && q.size() > 0) begin
                chk("swap", {63'b0, out_swap}, {63'b0, q[0].swap});
                chk("signBig", {63'b0, out_signBig}, {63'b0, q[0].sb});
                chk("signSmall", {63'b0, out_signSmall}, {63'b0, q[0].ss});
                chk("bigExp", {53'b0, out_bigExp}, {53'b0, q[0].be});
                chk("diff", {53'b0, out_diff}, {53'b0, q[0].df});
                chk("bigMan", {8'b0, out_bigMan}, {8'b0, q[0].bm});
                chk("smallMan", {8'b0, out_smallMan}, {8'b0, q[0].sm});
                if (in_outReady) begin
                    void'(q.pop_front());
                    rx++;
                end
            end
            if (in_flush) begin
                q.delete();
            end else if (in_valid && out_inReady) begin
                e     = model(in_signA, in_signB, in_expA, in_expB, in_manA, in_manB);
                e.acc = cyc + 1;
                q.push_back(e);
            end
        end
    end

    task automatic drive(input logic sa, input logic sb, input logic [10:0] ea,
                         input logic [10:0] eb, input logic [52:0] ma, input logic [52:0] mb);
        in_signA = sa; in_signB = sb;
        in_expA  = ea; in_expB  = eb;
        in_manA  = ma; in_manB  = mb;
    endtask

    // Present a pair and hold it until accepted (bounded).
    task automatic send(input logic sa, input logic sb, input logic [10:0] ea,
                        input logic [10:0] eb, input logic [52:0] ma, input logic [52:0] mb);
        int   n;
        logic acc;
        n   = 0;
        acc = 1'b0;
        drive(sa, sb, ea, eb, ma, mb);
        in_valid = 1'b1;
        while (!acc && n < 100) begin
            @(negedge clk);
            acc = out_inReady;
            @(posedge clk);
            #2;
            n++;
        end
        chk("send_accept", {63'b0, acc}, 64'd1);
        in_valid = 1'b0;
    endtask

    task automatic expect_out(input string tag, input logic swap, input logic sb, input logic ss,
                              input logic [10:0] be, input logic [10:0] df,
                              input logic [55:0] bm, input logic [55:0] sm);
        chk({tag, "_valid"}, {63'b0, out_valid}, 64'd1);
        chk({tag, "_swap"}, {63'b0, out_swap}, {63'b0, swap});
        chk({tag, "_signBig"}, {63'b0, out_signBig}, {63'b0, sb});
        chk({tag, "_signSmall"}, {63'b0, out_signSmall}, {63'b0, ss});
        chk({tag, "_bigExp"}, {53'b0, out_bigExp}, {53'b0, be});
        chk({tag, "_diff"}, {53'b0, out_diff}, {53'b0, df});
        chk({tag, "_bigMan"}, {8'b0, out_bigMan}, {8'b0, bm});
        chk({tag, "_smallMan"}, {8'b0, out_smallMan}, {8'b0, sm});
    endtask

    // Single pair, then look at the output two edges after acceptance.
    task automatic single(input string tag, input logic sa, input logic sb,
                          input logic [10:0] ea, input logic [10:0] eb,
                          input logic [52:0] ma, input logic [52:0] mb,
                          input logic swap, input logic xsb, input logic xss,
                          input logic [10:0] be, input logic [10:0] df,
                          input logic [55:0] bm, input logic [55:0] sm);
        send(sa, sb, ea, eb, ma, mb);
        @(posedge clk);
        @(negedge clk);
        expect_out(tag, swap, xsb, xss, be, df, bm, sm);
        @(posedge clk);
        #2;
    endtask

    localparam logic [52:0] HID = 53'h10000000000000;

    initial begin
        int rx0;
        in_outReady = 1'b1;
        #1;
        chk("reset_valid", {63'b0, out_valid}, 64'd0);
        chk("reset_inready", {63'b0, out_inReady}, 64'd1);
        chk("reset_swap", {63'b0, out_swap}, 64'd0);
        chk("reset_bigMan", {8'b0, out_bigMan}, 64'd0);
        chk("reset_smallMan", {8'b0, out_smallMan}, 64'd0);
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;

        // Literal vectors
        single("diff2", 1'b0, 1'b1, 11'h400, 11'h3FE, HID, HID,
               1'b0, 1'b0, 1'b1, 11'h400, 11'd2, 56'h80000000000000, 56'h20000000000000);
        single("eqexp", 1'b1, 1'b0, 11'h3FF, 11'h3FF, 53'h10000000000001, 53'h18000000000000,
               1'b1, 1'b0, 1'b1, 11'h3FF, 11'd0, 56'hC0000000000000, 56'h80000000000008);
        single("tie", 1'b1, 1'b0, 11'h3FF, 11'h3FF, HID, HID,
               1'b0, 1'b1, 1'b0, 11'h3FF, 11'd0, 56'h80000000000000, 56'h80000000000000);
        single("nowrap", 1'b1, 1'b0, 11'h000, 11'h7FE, 53'h1, HID,
               1'b1, 1'b0, 1'b1, 11'h7FE, 11'h7FE, 56'h80000000000000, 56'h1);
        single("diff56", 1'b0, 1'b0, 11'h438, 11'h400, HID, HID,
               1'b0, 1'b0, 1'b0, 11'h438, 11'd56, 56'h80000000000000, 56'h1);
        single("diff54", 1'b0, 1'b0, 11'h436, 11'h400, HID, HID,
               1'b0, 1'b0, 1'b0, 11'h436, 11'd54, 56'h80000000000000, 56'h2);
        single("sticky3", 1'b0, 1'b0, 11'h405, 11'h400, HID, 53'h1F,
               1'b0, 1'b0, 1'b0, 11'h405, 11'd5, 56'h80000000000000, 56'h7);

        // Back-to-back stream with a 3-cycle downstream stall
        rx0 = rx;
        saw_not_ready = 1'b0;
        fork
            begin
                for (int i = 0; i < 8; i++)
                    send(i[0], ~i[1], 11'h3F0 + 11'(i * 5), 11'h3F8 - 11'(i * 3),
                         HID | 53'(i * 32'h01234567), HID | 53'(32'h89ABCDEF >> i));
            end
            begin
                repeat (3) @(posedge clk);
                #2 in_outReady = 1'b0;
                repeat (3) @(posedge clk);
                #2 in_outReady = 1'b1;
            end
        join
        repeat (6) @(posedge clk);
        #2;
        chk("stream_count", 64'(rx - rx0), 64'd8);
        chk("stream_inready_dropped", {63'b0, saw_not_ready}, 64'd1);

        // Flush with both stages full and a new pair on the input
        in_outReady = 1'b0;
        send(1'b0, 1'b0, 11'h410, 11'h400, HID, HID);
        send(1'b0, 1'b0, 11'h420, 11'h400, HID, HID);
        rx0 = rx;
        drive(1'b1, 1'b1, 11'h430, 11'h400, HID, HID);
        in_valid = 1'b1;
        in_flush = 1'b1;
        @(posedge clk);
        #2;
        in_flush = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk("flush_valid", {63'b0, out_valid}, 64'd0);
        in_outReady = 1'b1;
        repeat (5) @(posedge clk);
        #2;
        chk("flush_no_emerge", 64'(rx - rx0), 64'd0);

        // Asynchronous reset mid-stream
        send(1'b0, 1'b1, 11'h401, 11'h400, HID, HID);
        send(1'b1, 1'b0, 11'h402, 11'h400, HID, HID);
        rst = 1'b1;
        #1;
        chk("rst_mid_valid", {63'b0, out_valid}, 64'd0);
        chk("rst_mid_inready", {63'b0, out_inReady}, 64'd1);
        chk("rst_mid_bigExp", {53'b0, out_bigExp}, 64'd0);
        chk("rst_mid_bigMan", {8'b0, out_bigMan}, 64'd0);
        chk("rst_mid_smallMan", {8'b0, out_smallMan}, 64'd0);
        @(posedge clk);
        #2 rst = 1'b0;
        single("post_rst", 1'b0, 1'b0, 11'h403, 11'h400, HID, HID,
               1'b0, 1'b0, 1'b0, 11'h403, 11'd3, 56'h80000000000000, 56'h10000000000000);
        repeat (3) @(posedge clk);
        #2;
        chk("final_drained", 64'(q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
